// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 responder with show-ahead RX FIFO and TX holding register
module spi_responder #(
  parameter int         RX_DEPTH    = 4,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] rx_dout,
  input  logic       rx_rd,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       rx_overflow,
  input  logic       ovf_clr,
  input  logic [7:0] tx_din,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       busy
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [AW:0]   PTR_ONE   = 1;
  localparam logic [FW-1:0] FLUSH_ONE = 1;
  localparam logic [FW-1:0] FLUSH_END = FW'(SYNC_STAGES);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;
  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic sck_prev_q, cs_prev_q;
  logic [FW-1:0] flush_q, flush_d;
  logic armed_q, armed_d;
  logic [7:0] tx_hold_q, tx_hold_d, tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic tx_full_q, tx_full_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic boundary_q, boundary_d, push_q, push_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic ovf_q, ovf_d;
  logic [7:0] mem_q [RX_DEPTH];

  logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_rise, cs_fall, flush_done;
  logic load_tx, do_pop, do_push, fifo_full, fifo_empty;
  logic [7:0] tx_next;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_prev_q;
  assign sck_fall   = ~sck_s & sck_prev_q;
  assign cs_rise    = cs_s & ~cs_prev_q;
  assign cs_fall    = ~cs_s & cs_prev_q;
  assign flush_done = (flush_q == FLUSH_END);

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop     = rx_rd & ~fifo_empty;
  assign do_push    = push_q & (~fifo_full | do_pop);
  assign tx_next    = tx_full_q ? tx_hold_q : IDLE_BYTE;

  // A low cs seen straight out of reset is not a fresh edge: frames arm only once cs reads high.
  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    boundary_d = boundary_q;
    push_d     = 1'b0;
    load_tx    = 1'b0;
    flush_d    = flush_done ? flush_q : flush_q + FLUSH_ONE;
    armed_d    = armed_q | (flush_done & cs_s);

    if (state_q != IDLE && cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (cs_fall && armed_q) state_d = LOAD;
        LOAD: begin
          state_d    = SHIFT;
          load_tx    = 1'b1;
          bit_cnt_d  = 3'd0;
          boundary_d = 1'b0;
        end
        SHIFT: begin
          if (sck_rise) begin
            rx_sr_d   = {rx_sr_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              boundary_d = 1'b1;
              push_d     = 1'b1;
            end
          end else if (sck_fall) begin
            if (boundary_q) begin
              load_tx    = 1'b1;
              boundary_d = 1'b0;
            end else begin
              tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (load_tx) tx_sr_d = tx_next;

    // A write coincident with a reload refills the holding register for the next byte.
    tx_hold_d = tx_hold_q;
    tx_full_d = tx_full_q;
    if (load_tx) tx_full_d = 1'b0;
    if (tx_wr && (!tx_full_q || load_tx)) begin
      tx_hold_d = tx_din;
      tx_full_d = 1'b1;
    end

    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ovf_d    = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (push_q && !do_push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      flush_q     <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      tx_hold_q   <= IDLE_BYTE;
      tx_sr_q     <= IDLE_BYTE;
      rx_sr_q     <= IDLE_BYTE;
      tx_full_q   <= 1'b0;
      bit_cnt_q   <= 3'd0;
      boundary_q  <= 1'b0;
      push_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sck_sync_q[0]  <= spi_sck;
      cs_sync_q[0]   <= spi_cs;
      mosi_sync_q[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync_q[i]  <= sck_sync_q[i-1];
        cs_sync_q[i]   <= cs_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
      flush_q    <= flush_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      tx_hold_q  <= tx_hold_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      tx_full_q  <= tx_full_d;
      bit_cnt_q  <= bit_cnt_d;
      boundary_q <= boundary_d;
      push_q     <= push_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= rx_sr_q;
  end

  assign spi_miso    = (state_q == IDLE) ? 1'b1 : tx_sr_q[7];
  assign rx_dout     = mem_q[rd_ptr_q[AW-1:0]];
  assign rx_empty    = fifo_empty;
  assign rx_full     = fifo_full;
  assign rx_overflow = ovf_q;
  assign tx_full     = tx_full_q;
  assign busy        = ~cs_s;
endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - scoreboard bench for spi_responder
module tb_spi_responder;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic Rst = 1'b1;
  logic spi_sck = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0;
  logic rx_rd = 1'b0, ovf_clr = 1'b0, tx_wr = 1'b0;
  logic [7:0] tx_din = 8'h00;
  logic spi_miso, rx_empty, rx_full, rx_overflow, tx_full, busy;
  logic [7:0] rx_dout;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_miso[$];
  logic [7:0] exp_rx[$];
  logic       m_vld = 1'b0;
  logic [7:0] m_byte = 8'h00;

  always #5 clk = ~clk;

  spi_responder #(.RX_DEPTH(4), .IDLE_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
    .clk(clk), .Rst(Rst), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .rx_dout(rx_dout), .rx_rd(rx_rd), .rx_empty(rx_empty),
    .rx_full(rx_full), .rx_overflow(rx_overflow), .ovf_clr(ovf_clr), .tx_din(tx_din),
    .tx_wr(tx_wr), .tx_full(tx_full), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: master-received bytes and FIFO pops are compared against the scoreboard queues.
  always @(negedge clk) begin
    logic [7:0] e;
    if (m_vld) begin
      tests++;
      if (exp_miso.size() == 0) begin
        fails++;
        $display("FAIL miso_byte: got %0h required none", m_byte);
      end else begin
        e = exp_miso.pop_front();
        if (m_byte !== e) begin
          fails++;
          $display("FAIL miso_byte: got %0h required %0h", m_byte, e);
        end
      end
    end
    if (rx_rd) begin
      tests++;
      if (exp_rx.size() == 0) begin
        fails++;
        $display("FAIL rx_pop: got %0h required none", rx_dout);
      end else begin
        e = exp_rx.pop_front();
        if (rx_empty !== 1'b0 || rx_dout !== e) begin
          fails++;
          $display("FAIL rx_pop: got %0h (rx_empty=%b) required %0h", rx_dout, rx_empty, e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wrtx(input logic [7:0] d);
    tx_din = d;
    tx_wr  = 1'b1;
    cyc(1);
    tx_wr  = 1'b0;
  endtask

  task automatic pop();
    rx_rd = 1'b1;
    cyc(1);
    rx_rd = 1'b0;
    cyc(1);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    cyc(HALF);
  endtask

  task automatic cs_high();
    cyc(HALF);
    spi_cs = 1'b1;
    cyc(HALF);
  endtask

  // mode 0: plain, 1: check push latency on 8th bit, 2: pop coincident with the push
  task automatic xfer(input logic [7:0] mo, input int nbits, input int mode);
    logic [7:0] mi;
    mi = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = mo[i];
      cyc(HALF);
      spi_sck = 1'b1;
      mi[i] = spi_miso;
      if (i == 0 && mode == 1) begin
        for (int k = 0; k < 4 && rx_empty; k++) cyc(1);
        check("rx_push_latency", rx_empty, 0);
        cyc(HALF);
      end else if (i == 0 && mode == 2) begin
        cyc(3);
        rx_rd = 1'b1;
        cyc(1);
        rx_rd = 1'b0;
        check("coincident_full", rx_full, 1);
        check("coincident_no_ovf", rx_overflow, 0);
        cyc(HALF - 4);
      end else begin
        cyc(HALF);
      end
      spi_sck = 1'b0;
    end
    if (nbits == 8) begin
      m_byte = mi;
      m_vld  = 1'b1;
      cyc(1);
      m_vld  = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, spi_miso, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tx_full"}, tx_full, 0);
    check({tag, "_rx_empty"}, rx_empty, 1);
    check({tag, "_rx_full"}, rx_full, 0);
    check({tag, "_rx_ovf"}, rx_overflow, 0);
  endtask

  logic [7:0] t2 [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    cyc(4);
    check_reset_outputs("reset");
    Rst = 1'b0;
    cyc(6);

    // Preloaded byte goes out while 3C comes in
    wrtx(8'hA5);
    check("tx_full_after_wr", tx_full, 1);
    exp_miso.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    cs_low();
    check("busy_in_frame", busy, 1);
    xfer(8'h3C, 8, 1);
    cs_high();
    check("tx_full_consumed", tx_full, 0);
    check("miso_idle", spi_miso, 1);
    pop();
    check("empty_after_t1", rx_empty, 1);

    // Three bytes with nothing queued for TX
    cs_low();
    for (int i = 0; i < 3; i++) begin
      exp_miso.push_back(8'hFF);
      exp_rx.push_back(t2[i]);
      xfer(t2[i], 8, 0);
    end
    cs_high();
    for (int i = 0; i < 3; i++) pop();
    check("empty_after_t2", rx_empty, 1);

    // Overflow on the fifth byte, then clear
    cs_low();
    for (int i = 1; i <= 5; i++) begin
      exp_miso.push_back(8'hFF);
      if (i <= 4) exp_rx.push_back(8'(i));
      xfer(8'(i), 8, 0);
    end
    cs_high();
    check("ovf_full", rx_full, 1);
    check("ovf_flag", rx_overflow, 1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", rx_overflow, 0);
    for (int i = 0; i < 4; i++) pop();
    check("empty_after_t3", rx_empty, 1);

    // Partial byte is discarded, next frame is byte-aligned again
    cs_low();
    xfer(8'hF0, 5, 0);
    cs_high();
    check("partial_no_push", rx_empty, 1);
    wrtx(8'h7E);
    exp_miso.push_back(8'h7E);
    exp_rx.push_back(8'h81);
    cs_low();
    xfer(8'h81, 8, 0);
    cs_high();
    pop();

    // Reset mid-byte aborts the frame
    wrtx(8'h33);
    cs_low();
    xfer(8'hAA, 4, 0);
    Rst = 1'b1;
    cyc(2);
    check_reset_outputs("midrst");
    Rst = 1'b0;
    cs_high();
    wrtx(8'h5A);
    exp_miso.push_back(8'h5A);
    exp_rx.push_back(8'hC3);
    cs_low();
    xfer(8'hC3, 8, 0);
    cs_high();
    pop();
    check("empty_after_t5", rx_empty, 1);

    // tx_wr coincident with LOAD, then pops coincident with pushes into a full FIFO
    wrtx(8'hC1);
    exp_miso.push_back(8'hC1);
    exp_miso.push_back(8'hC2);
    exp_miso.push_back(8'hFF);
    exp_miso.push_back(8'hFF);
    spi_cs = 1'b0;
    cyc(3);
    tx_din = 8'hC2;
    tx_wr  = 1'b1;
    cyc(1);
    tx_wr  = 1'b0;
    check("tx_wr_at_load", tx_full, 1);
    cyc(HALF);
    for (int i = 0; i < 4; i++) begin
      exp_rx.push_back(8'hA0 + 8'(i));
      xfer(8'hA0 + 8'(i), 8, 0);
    end
    check("fill_full", rx_full, 1);
    for (int i = 0; i < 4; i++) begin
      exp_miso.push_back(8'hFF);
      exp_rx.push_back(8'hB0 + 8'(i));
      xfer(8'hB0 + 8'(i), 8, 2);
    end
    cs_high();
    check("wrap_full", rx_full, 1);
    check("wrap_no_ovf", rx_overflow, 0);
    for (int i = 0; i < 4; i++) pop();
    check("empty_after_t6", rx_empty, 1);

    check("scoreboard_drained", exp_miso.size() + exp_rx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 Parameters SHALL be: RX_DEPTH, 4, receive FIFO depth (power of 2, >=2); IDLE_BYTE, 8'hFF, byte sent when no TX data is queued; SYNC_STAGES, 2, synchronizer flops on spi_sck/spi_cs/spi_mosi.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock; all logic on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- spi_sck  in  1  SPI serial clock from the external master; asynchronous to clk.
- spi_cs  in  1  chip select, active low; asynchronous.
- spi_mosi  in  1  master-out serial data; asynchronous.
- spi_miso  out  1  serial data to the master.
- rx_dout  out  8  head of the RX FIFO (show-ahead); valid while rx_empty=0.
- rx_rd  in  1  pops the RX FIFO head; ignored when empty.
- rx_empty  out  1  RX FIFO holds 0 bytes.
- rx_full  out  1  RX FIFO holds RX_DEPTH bytes.
- rx_overflow  out  1  sticky flag: a received byte was dropped.
- ovf_clr  in  1  clears rx_overflow.
- tx_din  in  8  next byte to transmit.
- tx_wr  in  1  writes tx_din into the TX holding register.
- tx_full  out  1  TX holding register occupied.
- busy  out  1  synchronized spi_cs is low (frame active).

Function
REQ-003 Protocol SHALL be SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit bytes; spi_mosi sampled on sck rising edges; spi_miso updated after sck falling edges.
REQ-004 spi_sck, spi_cs and spi_mosi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized sck and cs only, using a one-cycle edge pulse.
REQ-005 Supported operating envelope: sck high and low phases >= SYNC_STAGES+2 clk cycles; cs-fall to first sck rise >= SYNC_STAGES+3 clk cycles.
REQ-006 FSM states: IDLE (cs high), LOAD (one cycle, entered on the cs falling edge), SHIFT; IDLE->LOAD on cs fall; LOAD->SHIFT unconditionally; LOAD/SHIFT->IDLE on cs rise (priority over all edges).
REQ-007 LOAD SHALL copy the holding register into the TX shift register and clear tx_full if tx_full=1, else load IDLE_BYTE; the 3-bit bit counter and the boundary flag SHALL clear.
REQ-008 spi_miso SHALL equal TX shift register bit 7 in LOAD/SHIFT and 1 in IDLE.
REQ-009 On each sck rising edge in SHIFT: shift the synchronized mosi into the RX shift register LSB and increment the bit counter modulo 8; when the counter wraps 7->0, set the boundary flag and push the assembled byte to the RX FIFO in the next cycle.
REQ-010 On each sck falling edge in SHIFT: if the boundary flag is set, reload the TX shift register per REQ-007 rules and clear the flag; otherwise shift the TX register left by 1.
REQ-011 A cs rise mid-byte SHALL discard the partial RX byte (no push) and the rest of the TX byte. The holding register is unaffected.
REQ-012 RX push latency SHALL be <= SYNC_STAGES+2 clk cycles from the 8th sck rising edge at the pin to rx_empty=0.
REQ-013 A push into a full FIFO SHALL drop the byte and set rx_overflow. If rx_rd is asserted in the same cycle, the pop SHALL occur and the push SHALL be accepted (no overflow).
REQ-014 Occupancy SHALL be tracked with log2(RX_DEPTH)+1-bit pointers; wrap-around SHALL preserve FIFO order.
REQ-015 tx_wr while tx_full=1 SHALL be ignored. A tx_wr in the same cycle as a holding-register load SHALL be captured into the holding register for the following byte, with tx_full=1 after that cycle.
REQ-016 If ovf_clr and a new overflow occur in the same cycle, the overflow SHALL win (rx_overflow stays 1).

Reset
REQ-017 On Rst=1 at a clk edge: state=IDLE; FIFO pointers=0 (rx_empty=1, rx_full=0); rx_overflow=0; tx_full=0; bit counter and boundary flag=0; shift registers=IDLE_BYTE; synchronizer flops=1 for cs and 0 for sck/mosi; spi_miso=1; busy=0.
REQ-018 Rst asserted mid-frame SHALL abort the frame. A new frame SHALL be recognized only after a fresh cs falling edge.

Verification
REQ-019 Preload tx_wr 8'hA5; master frame sends 8'h3C -> master receives A5; rx_dout=3C, rx_empty=0 within 4 clk cycles; tx_full=0.
REQ-020 Frame of 3 bytes (11,22,33) with no TX data queued -> master receives FF,FF,FF; FIFO pops 11,22,33 in order.
REQ-021 Send 5 bytes with RX_DEPTH=4 and no reads -> rx_full=1, rx_overflow=1, FIFO holds bytes 1-4; ovf_clr clears the flag.
REQ-022 cs raised after 5 bits -> no push; next frame sending 8'h81 receives 81 correctly.
REQ-023 Rst pulse mid-byte, then a new frame with tx byte 8'h5A -> all outputs at reset values; master then receives 5A.
REQ-024 FIFO full with rx_rd coincident with a push -> no overflow; occupancy stays 4; order is preserved across pointer wrap.
